// File: rtl/simprisc_pkg.sv
// Shared SimpRisc types and defaults used by the register file and its users.
package simprisc_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    typedef logic [XLEN_DEFAULT-1:0] word_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the multi-port register file.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                      clr_req;
    logic                      busy;
    logic                      we;
    logic [AW-1:0]             waddr;
    logic [XLEN-1:0]           wdata;
    logic [NRD-1:0][AW-1:0]    raddr;
    logic [NRD-1:0][XLEN-1:0]  rdata;

    modport master (
        output clr_req, we, waddr, wdata, raddr,
        input  busy, rdata
    );

    modport slave (
        input  clr_req, we, waddr, wdata, raddr,
        output busy, rdata
    );
endinterface

// File: rtl/rf_read_port.sv
// One registered read port: array select, write-first bypass, r0 masking.
module rf_read_port #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter bit ZERO_R0 = 1'b1,
    parameter int AW      = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        clear,
    input  logic [NREGS-1:0][XLEN-1:0]  mem,
    input  logic [AW-1:0]               raddr,
    input  logic                        wr_en,
    input  logic [AW-1:0]               waddr,
    input  logic [XLEN-1:0]             wdata,
    output logic [XLEN-1:0]             rdata
);
    logic [XLEN-1:0] rdata_nxt;
    logic [XLEN-1:0] rdata_p1;

    // wr_en already excludes dropped writes, so a matching address always bypasses
    always_comb begin
        rdata_nxt = mem[raddr];
        if (clear) begin
            rdata_nxt = '0;
        end else if (ZERO_R0 && (raddr == '0)) begin
            rdata_nxt = '0;
        end else if (wr_en && (waddr == raddr)) begin
            rdata_nxt = wdata;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata_p1 <= '0;
        end else begin
            rdata_p1 <= rdata_nxt;
        end
    end

    assign rdata = rdata_p1;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and a sequential clear
// engine that zeroes the array after reset or on request.
module regfile_mp
    import simprisc_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic          clk,
    input  logic          nreset,
    regfile_mp_if.slave   rf
);
    localparam int AW = $clog2(NREGS);

    rf_state_e                 state, state_nxt;
    logic [AW-1:0]             clr_idx, clr_idx_nxt;
    logic                      busy_q;
    logic                      wr_en;
    logic                      clearing;
    logic [NREGS-1:0][XLEN-1:0] mem;
    logic [NRD-1:0][XLEN-1:0]  rdata_w;

    assign clearing = (state == RF_CLEAR);

    // A clear request in the same cycle as a write wins; the write is lost.
    assign wr_en = !clearing && !rf.clr_req && rf.we
                   && !(ZERO_R0 && (rf.waddr == '0));

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            RF_CLEAR: begin
                clr_idx_nxt = clr_idx + 1'b1;
                if (clr_idx == AW'(NREGS - 1)) begin
                    state_nxt = RF_IDLE;
                end
            end
            RF_IDLE: begin
                if (rf.clr_req) begin
                    state_nxt   = RF_CLEAR;
                    clr_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt   = RF_CLEAR;
                clr_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            busy_q  <= (state_nxt == RF_CLEAR);
        end
    end

    // Storage carries no reset; the clear engine is what initialises it.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            mem[rf.waddr] <= rf.wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        rf_read_port #(
            .XLEN    (XLEN),
            .NREGS   (NREGS),
            .ZERO_R0 (ZERO_R0),
            .AW      (AW)
        ) u_rp (
            .clk    (clk),
            .nreset (nreset),
            .clear  (clearing),
            .mem    (mem),
            .raddr  (rf.raddr[i]),
            .wr_en  (wr_en),
            .waddr  (rf.waddr),
            .wdata  (rf.wdata),
            .rdata  (rdata_w[i])
        );
    end

    assign rf.rdata = rdata_w;
    assign rf.busy  = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one instance with ZERO_R0=1, one with
// ZERO_R0=0, driven identically and checked against hand-computed values.
module tb_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 nreset  = 1'b0;
    logic                 clr_req = 1'b0;
    logic                 we      = 1'b0;
    logic [4:0]           waddr   = '0;
    logic [31:0]          wdata   = '0;
    logic [1:0][4:0]      raddr   = '0;
    logic                 rd_vld  = 1'b0;
    logic                 vld_p1  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0][31:0] ez;
        logic [1:0][31:0] en;
    } exp_t;
    exp_t sb[$];

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifz ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifn ();

    assign ifz.clr_req = clr_req;  assign ifn.clr_req = clr_req;
    assign ifz.we      = we;       assign ifn.we      = we;
    assign ifz.waddr   = waddr;    assign ifn.waddr   = waddr;
    assign ifz.wdata   = wdata;    assign ifn.wdata   = wdata;
    assign ifz.raddr   = raddr;    assign ifn.raddr   = raddr;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .nreset(nreset), .rf(ifz)
    );
    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_R0(1'b0)) dut_n (
        .clk(clk), .nreset(nreset), .rf(ifn)
    );

    always @(posedge clk) vld_p1 <= rd_vld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per checked read, consumed the cycle after issue.
    always @(negedge clk) begin
        if (vld_p1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_z0", ifz.rdata[0], e.ez[0]);
                chk("rd_z1", ifz.rdata[1], e.ez[1]);
                chk("rd_n0", ifn.rdata[0], e.en[0]);
                chk("rd_n1", ifn.rdata[1], e.en[1]);
            end
        end
    end

    task automatic issue(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a0, input logic [4:0] a1, input logic clr,
                         input logic c, input logic [31:0] z0, input logic [31:0] z1,
                         input logic [31:0] n0, input logic [31:0] n1);
        exp_t e;
        we = w; waddr = wa; wdata = wd;
        raddr[0] = a0; raddr[1] = a1;
        clr_req = clr; rd_vld = c;
        if (c) begin
            e.ez[0] = z0; e.ez[1] = z1; e.en[0] = n0; e.en[1] = n1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        we = 1'b0; clr_req = 1'b0; rd_vld = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        issue(1'b1, a, d, 5'd0, 5'd0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] z0, input logic [31:0] z1,
                       input logic [31:0] n0, input logic [31:0] n1);
        issue(1'b0, 5'd0, '0, a0, a1, 1'b0, 1'b1, z0, z1, n0, n1);
    endtask

    // Steps while busy, trying a write to r9 and one extra clr_req; reads must be 0.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (ifz.busy && n < 100) begin
            issue(1'b1, 5'd9, 32'h0000_0099, 5'd3, 5'd9, (n == 4), 1'b1, '0, '0, '0, '0);
            n++;
        end
        chk(name, 32'(n), 32'd32);
        chk({name, "_nz"}, 32'(ifn.busy), 32'd0);
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < 32; a += 2) begin
            rd2(5'(a), 5'(a + 1), '0, '0, '0, '0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy_z", 32'(ifz.busy), 32'd1);
        chk("rst_busy_n", 32'(ifn.busy), 32'd1);
        chk("rst_rd_z0", ifz.rdata[0], '0);
        chk("rst_rd_n1", ifn.rdata[1], '0);
        @(posedge clk); #1;
        nreset = 1'b1;
        count_busy("busy_after_reset");
        read_all_zero();

        wr(5'd5, 32'hDEAD_BEEF);
        rd2(5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        wr(5'd6, 32'h6666_6666);
        issue(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd6, 1'b0, 1'b1,
              32'h1234_5678, 32'h6666_6666, 32'h1234_5678, 32'h6666_6666);
        rd2(5'd7, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF);

        issue(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 1'b1,
              '0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd2(5'd0, 5'd7, '0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678);

        for (int a = 1; a < 32; a++) wr(5'(a), 32'hA5A5_A5A5);
        rd2(5'd3, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        // clr_req with a write to r3: reads complete normally, no bypass of the dropped write
        issue(1'b1, 5'd3, 32'h0000_0001, 5'd3, 5'd0, 1'b1, 1'b1,
              32'hA5A5_A5A5, '0, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        chk("clr_busy_start", 32'(ifz.busy), 32'd1);
        count_busy("busy_after_clr");
        read_all_zero();

        issue(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b0, '0, '0, '0, '0);
        repeat (10) issue(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, '0, '0, '0, '0);
        nreset = 1'b0;
        @(negedge clk);
        chk("midclr_rst_busy", 32'(ifz.busy), 32'd1);
        chk("midclr_rst_rd", ifz.rdata[0] | ifn.rdata[1], '0);
        @(posedge clk); @(posedge clk); #1;
        nreset = 1'b1;
        count_busy("busy_after_midclr_rst");
        read_all_zero();

        repeat (3) @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
